// File: rtl/reorder_buffer_if.sv
// Reorder buffer channel bundle: issue allocation, commit write
// and in-order writeback read, grouped for one port connection.
interface reorder_buffer_if #(
    parameter int DEPTH   = 64,
    parameter int ENTRY_W = 64
);
    localparam int TAG_W = $clog2(DEPTH);

    logic               alloc_i;
    logic [TAG_W-1:0]   alloc_tag_o;
    logic               full_o;
    logic               empty_o;
    logic               write_i;
    logic [TAG_W-1:0]   write_tag_i;
    logic [ENTRY_W-1:0] write_entry_i;
    logic               read_valid_o;
    logic               read_ready_i;
    logic [TAG_W-1:0]   read_tag_o;
    logic [ENTRY_W-1:0] read_entry_o;

    // Buffer side.
    modport slave (
        input  alloc_i,
        output alloc_tag_o,
        output full_o,
        output empty_o,
        input  write_i,
        input  write_tag_i,
        input  write_entry_i,
        output read_valid_o,
        input  read_ready_i,
        output read_tag_o,
        output read_entry_o
    );

    // Issue / commit / writeback side.
    modport master (
        output alloc_i,
        input  alloc_tag_o,
        input  full_o,
        input  empty_o,
        output write_i,
        output write_tag_i,
        output write_entry_i,
        input  read_valid_o,
        output read_ready_i,
        input  read_tag_o,
        input  read_entry_o
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tags allocated in program order,
// results written out of order, head drained in order.
module reorder_buffer #(
    parameter int DEPTH   = 64,
    parameter int ENTRY_W = 64,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic stall_i,
    reorder_buffer_if.slave rob
);
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [TAG_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   alloc_q, alloc_d;
    logic [DEPTH-1:0]   written_q, written_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic read_valid;
    logic do_alloc;
    logic do_write;
    logic do_retire;

    // Status and handshake decode from registered state.
    always_comb begin
        full       = (count_q == (TAG_W+1)'(DEPTH));
        empty      = (count_q == '0);
        read_valid = alloc_q[head_q] & written_q[head_q] & ~stall_i;
        do_alloc   = rob.alloc_i & ~full;
        do_write   = rob.write_i & alloc_q[rob.write_tag_i];
        do_retire  = read_valid & rob.read_ready_i;
    end

    // Output drive; entry is masked to zero when the head is not valid.
    always_comb begin
        rob.alloc_tag_o  = tail_q;
        rob.full_o       = full;
        rob.empty_o      = empty;
        rob.read_valid_o = read_valid;
        rob.read_tag_o   = head_q;
        rob.read_entry_o = read_valid ? mem_q[head_q] : '0;
    end

    // Next-state for pointers, occupancy and per-slot flags.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        alloc_d   = alloc_q;
        written_d = written_q;
        if (flush_i) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            alloc_d   = '0;
            written_d = '0;
        end else begin
            if (do_retire) begin
                alloc_d[head_q]   = 1'b0;
                written_d[head_q] = 1'b0;
                head_d            = head_q + TAG_W'(1);
            end
            if (do_alloc) begin
                alloc_d[tail_q]   = 1'b1;
                written_d[tail_q] = 1'b0;
                tail_d            = tail_q + TAG_W'(1);
            end
            if (do_write) begin
                written_d[rob.write_tag_i] = 1'b1;
            end
            unique case ({do_alloc, do_retire})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            alloc_q   <= '0;
            written_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            alloc_q   <= alloc_d;
            written_q <= written_d;
        end
    end

    // Entry storage; contents only matter once the written flag is set.
    always_ff @(posedge clk_i) begin
        if (do_write && !flush_i) begin
            mem_q[rob.write_tag_i] <= rob.write_entry_i;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for in-order
// retirement, hand sequences for full, wrap, stall, flush, reset.
module tb_reorder_buffer;
    localparam int DEPTH   = 64;
    localparam int ENTRY_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic stall = 1'b0;
    int   total = 0;
    int   bad   = 0;

    reorder_buffer_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .stall_i (stall),
        .rob     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a;
        logic        w;
        logic [5:0]  t;
        logic [63:0] e;
        logic        rdy;
        logic        v;
        logic [5:0]  tg;
        logic [63:0] ent;
        logic [5:0]  at;
        logic        emp;
        logic        ful;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs
    // settle by the time the caller checks, the state update happens
    // at the following rising edge.
    task automatic cyc(input logic a, input logic w, input logic [5:0] t,
                       input logic [63:0] e, input logic rdy,
                       input logic st, input logic fl);
        @(negedge clk);
        bus.alloc_i       = a;
        bus.write_i       = w;
        bus.write_tag_i   = t;
        bus.write_entry_i = e;
        bus.read_ready_i  = rdy;
        stall             = st;
        flush             = fl;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0]  t;
        logic [63:0] ev;

        bus.alloc_i       = 1'b0;
        bus.write_i       = 1'b0;
        bus.write_tag_i   = '0;
        bus.write_entry_i = '0;
        bus.read_ready_i  = 1'b0;

        tv[0]  = '{1,0,0,64'h0 ,0, 0,0,64'h0 ,0,1,0};
        tv[1]  = '{1,0,0,64'h0 ,0, 0,0,64'h0 ,1,0,0};
        tv[2]  = '{1,0,0,64'h0 ,0, 0,0,64'h0 ,2,0,0};
        tv[3]  = '{0,1,2,64'hAA,1, 0,0,64'h0 ,3,0,0};
        tv[4]  = '{0,1,0,64'hBB,1, 0,0,64'h0 ,3,0,0};
        tv[5]  = '{0,0,0,64'h0 ,1, 1,0,64'hBB,3,0,0};
        tv[6]  = '{0,0,0,64'h0 ,1, 0,1,64'h0 ,3,0,0};
        tv[7]  = '{0,1,1,64'hCC,1, 0,1,64'h0 ,3,0,0};
        tv[8]  = '{0,0,0,64'h0 ,0, 1,1,64'hCC,3,0,0};
        tv[9]  = '{0,0,0,64'h0 ,1, 1,1,64'hCC,3,0,0};
        tv[10] = '{0,0,0,64'h0 ,1, 1,2,64'hAA,3,0,0};
        tv[11] = '{0,0,0,64'h0 ,1, 0,3,64'h0 ,3,1,0};

        #12;
        @(negedge clk);
        rst = 1'b0;

        idle();
        chk("rst_empty", 64'(bus.empty_o), 64'd1);
        chk("rst_full", 64'(bus.full_o), 64'd0);
        chk("rst_atag", 64'(bus.alloc_tag_o), 64'd0);
        chk("rst_valid", 64'(bus.read_valid_o), 64'd0);
        chk("rst_rtag", 64'(bus.read_tag_o), 64'd0);
        chk("rst_entry", bus.read_entry_o, 64'd0);

        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].a, tv[i].w, tv[i].t, tv[i].e, tv[i].rdy, 1'b0, 1'b0);
            chk($sformatf("v%0d_valid", i), 64'(bus.read_valid_o), 64'(tv[i].v));
            chk($sformatf("v%0d_rtag", i), 64'(bus.read_tag_o), 64'(tv[i].tg));
            chk($sformatf("v%0d_entry", i), bus.read_entry_o, tv[i].ent);
            chk($sformatf("v%0d_atag", i), 64'(bus.alloc_tag_o), 64'(tv[i].at));
            chk($sformatf("v%0d_empty", i), 64'(bus.empty_o), 64'(tv[i].emp));
            chk($sformatf("v%0d_full", i), 64'(bus.full_o), 64'(tv[i].ful));
        end

        // Fill all 64 slots, then try a 65th alloc.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
            chk("fill_atag", 64'(bus.alloc_tag_o), 64'(i));
            chk("fill_notfull", 64'(bus.full_o), 64'd0);
        end
        cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("full_set", 64'(bus.full_o), 64'd1);
        chk("full_atag", 64'(bus.alloc_tag_o), 64'd0);
        idle();
        chk("ovf_ignored_full", 64'(bus.full_o), 64'd1);
        chk("ovf_ignored_atag", 64'(bus.alloc_tag_o), 64'd0);

        // Full with tag 0 written: retire and alloc together.
        cyc(1'b0, 1'b1, 6'd0, 64'h11, 1'b0, 1'b0, 1'b0);
        chk("fw_novalid_yet", 64'(bus.read_valid_o), 64'd0);
        cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        chk("fr_valid", 64'(bus.read_valid_o), 64'd1);
        chk("fr_entry", bus.read_entry_o, 64'h11);
        chk("fr_full", 64'(bus.full_o), 64'd1);
        idle();
        chk("fr_after_full", 64'(bus.full_o), 64'd0);
        chk("fr_after_empty", 64'(bus.empty_o), 64'd0);
        chk("fr_after_atag", 64'(bus.alloc_tag_o), 64'd0);
        chk("fr_after_rtag", 64'(bus.read_tag_o), 64'd1);

        // Wrap: count 63, retire two, alloc 63, 0, 1 on the next lap.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++)
            cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 6'd0, 64'h100, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 6'd1, 64'h101, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        chk("wr_ret0", bus.read_entry_o, 64'h100);
        cyc(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        chk("wr_ret1", bus.read_entry_o, 64'h101);
        cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("wr_tag63", 64'(bus.alloc_tag_o), 64'd63);
        cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("wr_tag0", 64'(bus.alloc_tag_o), 64'd0);
        cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("wr_tag1", 64'(bus.alloc_tag_o), 64'd1);
        cyc(1'b0, 1'b1, 6'd0, 64'h5A, 1'b0, 1'b0, 1'b0);
        chk("wr_full", 64'(bus.full_o), 64'd1);
        cyc(1'b0, 1'b1, 6'd1, 64'h5B, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < DEPTH; i++)
            cyc(1'b0, 1'b1, 6'(i), 64'h1000 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            t  = 6'(k + 2);
            ev = (t == 6'd0) ? 64'h5A :
                 (t == 6'd1) ? 64'h5B : 64'h1000 + 64'(t);
            cyc(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0);
            chk("wrd_valid", 64'(bus.read_valid_o), 64'd1);
            chk("wrd_tag", 64'(bus.read_tag_o), 64'(t));
            chk("wrd_entry", bus.read_entry_o, ev);
        end
        idle();
        chk("wrd_empty", 64'(bus.empty_o), 64'd1);

        // Stall blocks retirement but not alloc or write.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b0);
            chk("st_alloc_atag", 64'(bus.alloc_tag_o), 64'(i));
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 6'(i), 64'h200 + 64'(i), 1'b1, 1'b1, 1'b0);
            chk("st_valid", 64'(bus.read_valid_o), 64'd0);
        end
        cyc(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b0);
        chk("st_hold_valid", 64'(bus.read_valid_o), 64'd0);
        chk("st_hold_entry", bus.read_entry_o, 64'd0);
        cyc(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("st_rel_valid", 64'(bus.read_valid_o), 64'd1);
        chk("st_rel_entry", bus.read_entry_o, 64'h200);
        chk("st_atag", 64'(bus.alloc_tag_o), 64'd5);

        // Flush overrides a concurrent alloc and write.
        cyc(1'b1, 1'b1, 6'd1, 64'h999, 1'b0, 1'b0, 1'b1);
        idle();
        chk("fl_empty", 64'(bus.empty_o), 64'd1);
        chk("fl_atag", 64'(bus.alloc_tag_o), 64'd0);
        chk("fl_valid", 64'(bus.read_valid_o), 64'd0);
        chk("fl_full", 64'(bus.full_o), 64'd0);

        // Asynchronous reset between clock edges.
        cyc(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 6'd0, 64'h77, 1'b0, 1'b0, 1'b0);
        idle();
        chk("ar_pre_valid", 64'(bus.read_valid_o), 64'd1);
        chk("ar_pre_entry", bus.read_entry_o, 64'h77);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(bus.read_valid_o), 64'd0);
        chk("ar_entry", bus.read_entry_o, 64'd0);
        chk("ar_atag", 64'(bus.alloc_tag_o), 64'd0);
        chk("ar_empty", 64'(bus.empty_o), 64'd1);
        chk("ar_full", 64'(bus.full_o), 64'd0);
        chk("ar_rtag", 64'(bus.read_tag_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
